// File: rtl/rpn_pkg.sv
// Shared opcodes, error codes and FSM state type for the RPN sequencer.
package rpn_pkg;

  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_MUL = 4'b0100;
  localparam logic [3:0] OP_DIV = 4'b1000;

  localparam logic [2:0] ERR_NONE  = 3'd0;
  localparam logic [2:0] ERR_OVF   = 3'd1;
  localparam logic [2:0] ERR_UNF   = 3'd2;
  localparam logic [2:0] ERR_BADOP = 3'd3;
  localparam logic [2:0] ERR_DIV0  = 3'd4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_ERR
  } state_t;

  function automatic logic op_valid(input logic [3:0] op);
    return op inside {OP_ADD, OP_SUB, OP_MUL, OP_DIV};
  endfunction

endpackage

// File: rtl/rpn_stack.sv
// Operand register stack: push, replace-second-and-pop, clear.
module rpn_stack #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 8,
  localparam int CW    = $clog2(DEPTH + 1),
  localparam int IW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop_replace,
  input  logic [DATA_W-1:0] replace_data,
  output logic [CW-1:0]     count,
  output logic [DATA_W-1:0] top,
  output logic [DATA_W-1:0] second
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [CW-1:0]     top_idx;
  logic [CW-1:0]     sec_idx;

  assign top_idx = count - CW'(1);
  assign sec_idx = count - CW'(2);

  assign top = (count == '0) ? '0
             : mem[top_idx[IW-1:0]];
  assign second = (count < CW'(2)) ? '0
                : mem[sec_idx[IW-1:0]];

  // Contents are don't-care after reset, so the array carries no reset.
  always_ff @(posedge clk) begin
    if (!clr) begin
      if (push)
        mem[count[IW-1:0]] <= push_data;
      else if (pop_replace)
        mem[sec_idx[IW-1:0]] <= replace_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      count <= '0;
    else if (clr)
      count <= '0;
    else if (push)
      count <= count + CW'(1);
    else if (pop_replace)
      count <= count - CW'(1);
  end

endmodule

// File: rtl/rpn_sequencer.sv
// RPN token sequencer driving an external combinational ALU.
// Define RPN_DIV0_TRAP_EN to reject divide-by-zero with err_code 4.
module rpn_sequencer
  import rpn_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 8,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_is_op,
  input  logic [DATA_W-1:0] in_data,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [3:0]        alu_op,
  input  logic [DATA_W-1:0] alu_y,
  output logic [DATA_W-1:0] top,
  output logic [CW-1:0]     count,
  output logic              busy,
  output logic              err,
  output logic [2:0]        err_code
);

  state_t            state;
  state_t            state_n;
  logic [DATA_W-1:0] a_n;
  logic [DATA_W-1:0] b_n;
  logic [3:0]        op_n;
  logic [2:0]        code_n;
  logic              push;
  logic              pop_replace;
  logic [DATA_W-1:0] second;
  logic [3:0]        tok_op;
  logic              div0;

  assign tok_op = in_data[3:0];
  assign err    = (err_code != ERR_NONE);

`ifdef RPN_DIV0_TRAP_EN
  assign div0 = (tok_op == OP_DIV) && (top == '0);
`else
  assign div0 = 1'b0;
`endif

  rpn_stack #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH)
  ) u_stack (
    .clk         (clk),
    .rst         (rst),
    .clr         (clr),
    .push        (push),
    .push_data   (in_data),
    .pop_replace (pop_replace),
    .replace_data(alu_y),
    .count       (count),
    .top         (top),
    .second      (second)
  );

  always_comb begin
    state_n     = state;
    a_n         = alu_a;
    b_n         = alu_b;
    op_n        = alu_op;
    code_n      = err_code;
    push        = 1'b0;
    pop_replace = 1'b0;
    in_ready    = 1'b0;
    busy        = 1'b0;
    case (state)
      S_IDLE: begin
        in_ready = 1'b1;
        op_n     = '0;
        if (in_valid && !in_is_op) begin
          if (count < CW'(DEPTH)) begin
            push = 1'b1;
          end else begin
            code_n  = ERR_OVF;
            state_n = S_ERR;
          end
        end else if (in_valid) begin
          if (!op_valid(tok_op)) begin
            code_n  = ERR_BADOP;
            state_n = S_ERR;
          end else if (count < CW'(2)) begin
            code_n  = ERR_UNF;
            state_n = S_ERR;
          end else if (div0) begin
            code_n  = ERR_DIV0;
            state_n = S_ERR;
          end else begin
            a_n     = second;
            b_n     = top;
            op_n    = tok_op;
            state_n = S_EXEC;
          end
        end
      end
      S_EXEC: begin
        busy        = 1'b1;
        pop_replace = 1'b1;
        op_n        = '0;
        state_n     = S_IDLE;
      end
      S_ERR: ;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      alu_a    <= '0;
      alu_b    <= '0;
      alu_op   <= '0;
      err_code <= ERR_NONE;
    end else if (clr) begin
      state    <= S_IDLE;
      alu_a    <= '0;
      alu_b    <= '0;
      alu_op   <= '0;
      err_code <= ERR_NONE;
    end else begin
      state    <= state_n;
      alu_a    <= a_n;
      alu_b    <= b_n;
      alu_op   <= op_n;
      err_code <= code_n;
    end
  end

endmodule

// File: tb/tb_rpn_sequencer.sv
// Self-checking bench for rpn_sequencer against a queue-based RPN model.
module tb_rpn_sequencer;

  localparam int DW = 32;
  localparam int DP = 8;

  logic          clk = 0;
  logic          rst = 1;
  logic          clr = 0;
  logic          in_valid = 0;
  logic          in_ready;
  logic          in_is_op = 0;
  logic [DW-1:0] in_data = '0;
  logic [DW-1:0] alu_a;
  logic [DW-1:0] alu_b;
  logic [3:0]    alu_op;
  logic [DW-1:0] alu_y;
  logic [DW-1:0] top;
  logic [3:0]    count;
  logic          busy;
  logic          err;
  logic [2:0]    err_code;

  int checks = 0;
  int passed = 0;

  logic [DW-1:0] mq[$];
  int            merr = 0;

  logic          ex_busy;
  logic          ex_ready;
  logic [DW-1:0] ex_a;
  logic [DW-1:0] ex_b;
  logic [3:0]    ex_op;

`ifdef RPN_DIV0_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  always #5 clk = ~clk;

  // The ALU that sits beside the sequencer
  always_comb begin
    alu_y = '0;
    case (alu_op)
      4'b0001: alu_y = alu_a + alu_b;
      4'b0010: alu_y = alu_a - alu_b;
      4'b0100: alu_y = alu_a * alu_b;
      4'b1000: alu_y = (alu_b == 0) ? '0 : alu_a / alu_b;
      default: alu_y = '0;
    endcase
  end

  rpn_sequencer #(.DATA_W(DW), .DEPTH(DP)) dut (
    .clk(clk), .rst(rst), .clr(clr),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_is_op(in_is_op), .in_data(in_data),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_y(alu_y), .top(top), .count(count),
    .busy(busy), .err(err), .err_code(err_code)
  );

  // Reference model: returns 1 if the token starts an operation.
  function automatic bit model_accept(input bit is_op,
                                      input logic [DW-1:0] d);
    logic [DW-1:0] a, b, r;
    int code;
    if (merr != 0) return 0;
    if (!is_op) begin
      if (mq.size() < DP) mq.push_back(d);
      else merr = 1;
      return 0;
    end
    code = int'(d[3:0]);
    if (!(code inside {1, 2, 4, 8})) begin
      merr = 3; return 0;
    end
    if (mq.size() < 2) begin
      merr = 2; return 0;
    end
    if (TRAP && code == 8 && mq[$] == 0) begin
      merr = 4; return 0;
    end
    b = mq.pop_back();
    a = mq.pop_back();
    case (code)
      1: r = a + b;
      2: r = a - b;
      4: r = a * b;
      default: r = (b == 0) ? '0 : a / b;
    endcase
    mq.push_back(r);
    return 1;
  endfunction

  function automatic logic [41:0] exp_vec();
    logic [DW-1:0] t;
    t = (mq.size() > 0) ? mq[$] : '0;
    return {4'(mq.size()), t, merr != 0, 3'(merr),
            merr == 0, 1'b0};
  endfunction

  function automatic logic [41:0] obs_vec();
    return {count, top, err, err_code, in_ready, busy};
  endfunction

  task automatic apply(input bit is_op, input logic [DW-1:0] d);
    bit go;
    @(negedge clk);
    in_valid = 1; in_is_op = is_op; in_data = d;
    go = model_accept(is_op, d);
    @(posedge clk); #1;
    in_valid = 0; in_is_op = 0; in_data = '0;
    if (go) begin
      ex_busy = busy; ex_ready = in_ready;
      ex_a = alu_a; ex_b = alu_b; ex_op = alu_op;
      @(posedge clk); #1;
    end
  endtask

  task automatic do_clr();
    @(negedge clk); clr = 1;
    @(posedge clk); #1; clr = 0;
    mq.delete(); merr = 0;
  endtask

  task automatic test_reset();
    rst = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({obs_vec(), alu_a, alu_b, alu_op} !==
        {exp_vec(), 32'h0, 32'h0, 4'h0})
      $display("FAIL reset: got %h want %h",
               {obs_vec(), alu_a, alu_b, alu_op},
               {exp_vec(), 32'h0, 32'h0, 4'h0});
    else passed++;
    rst = 0;
  endtask

  task automatic test_add();
    do_clr();
    apply(0, 5); apply(0, 3); apply(1, 1);
    @(negedge clk);
    checks++;
    if (obs_vec() !== exp_vec())
      $display("FAIL add_state: got %h want %h", obs_vec(), exp_vec());
    else passed++;
    checks++;
    if ({count, top} !== {4'd1, 32'd8})
      $display("FAIL add_value: got %0d/%0d want 1/8", count, top);
    else passed++;
    checks++;
    if ({ex_busy, ex_ready, in_ready} !== 3'b101)
      $display("FAIL add_ready: busy/ready/after %b want 101",
               {ex_busy, ex_ready, in_ready});
    else passed++;
    checks++;
    if ({ex_a, ex_b, ex_op, alu_op} !== {32'd5, 32'd3, 4'b0001, 4'b0})
      $display("FAIL add_alu: got %h %h %b %b",
               ex_a, ex_b, ex_op, alu_op);
    else passed++;
  endtask

  task automatic test_sub_mul();
    do_clr();
    apply(0, 0); apply(0, 32'h0000FFFF); apply(1, 2);
    @(negedge clk);
    checks++;
    if (top !== 32'hFFFF0001 || obs_vec() !== exp_vec())
      $display("FAIL sub: got %h want %h", obs_vec(), exp_vec());
    else passed++;
    apply(0, 32'hFFFF); apply(0, 32'hFFFF); apply(1, 4);
    @(negedge clk);
    checks++;
    if (top !== 32'hFFFE0001 || obs_vec() !== exp_vec())
      $display("FAIL mul: got %h want %h", obs_vec(), exp_vec());
    else passed++;
  endtask

  task automatic test_div0();
    do_clr();
    apply(0, 7); apply(0, 0); apply(1, 8);
    @(negedge clk);
    checks++;
    if (obs_vec() !== exp_vec())
      $display("FAIL div0: got %h want %h", obs_vec(), exp_vec());
    else passed++;
    checks++;
    if (TRAP && {err, err_code, count, top} !== {1'b1, 3'd4, 4'd2, 32'd0})
      $display("FAIL div0_trap: got %b %0d %0d %h",
               err, err_code, count, top);
    else if (!TRAP && {err, count, top} !== {1'b0, 4'd1, 32'd0})
      $display("FAIL div0_exec: got %b %0d %h", err, count, top);
    else passed++;
  endtask

  task automatic test_overflow();
    do_clr();
    for (int i = 0; i < DP + 1; i++) apply(0, DW'(i + 1));
    @(negedge clk);
    checks++;
    if ({err_code, count, in_ready} !== {3'd1, 4'(DP), 1'b0} ||
        obs_vec() !== exp_vec())
      $display("FAIL overflow: got %h want %h", obs_vec(), exp_vec());
    else passed++;
    apply(0, 99);
    @(negedge clk);
    checks++;
    if (obs_vec() !== exp_vec())
      $display("FAIL err_frozen: got %h want %h", obs_vec(), exp_vec());
    else passed++;
    do_clr();
    @(negedge clk);
    checks++;
    if ({count, err, in_ready} !== 6'b0000_01)
      $display("FAIL clr: got %h", {count, err, in_ready});
    else passed++;
  endtask

  task automatic test_underflow_badop();
    do_clr();
    apply(0, 11); apply(1, 1);
    @(negedge clk);
    checks++;
    if (err_code !== 3'd2 || obs_vec() !== exp_vec())
      $display("FAIL underflow: got %h want %h", obs_vec(), exp_vec());
    else passed++;
    do_clr();
    apply(0, 1); apply(0, 2); apply(1, 3);
    @(negedge clk);
    checks++;
    if ({err_code, count, top} !== {3'd3, 4'd2, 32'd2} ||
        obs_vec() !== exp_vec())
      $display("FAIL badop: got %h want %h", obs_vec(), exp_vec());
    else passed++;
  endtask

  task automatic test_rst_exec();
    do_clr();
    apply(0, 4); apply(0, 6);
    @(negedge clk);
    in_valid = 1; in_is_op = 1; in_data = 2;
    @(posedge clk); #1;
    in_valid = 0; in_is_op = 0; in_data = '0;
    checks++;
    if (busy !== 1'b1)
      $display("FAIL rst_exec_busy: got %b want 1", busy);
    else passed++;
    rst = 1; #1;
    checks++;
    if ({obs_vec(), alu_a, alu_b, alu_op} !==
        {4'd0, 32'd0, 1'b0, 3'd0, 1'b1, 1'b0, 32'd0, 32'd0, 4'd0})
      $display("FAIL rst_exec: got %h",
               {obs_vec(), alu_a, alu_b, alu_op});
    else passed++;
    @(negedge clk); rst = 0;
    mq.delete(); merr = 0;
    apply(0, 9);
    @(negedge clk);
    checks++;
    if ({count, top} !== {4'd1, 32'd9} || obs_vec() !== exp_vec())
      $display("FAIL rst_resume: got %h want %h", obs_vec(), exp_vec());
    else passed++;
  endtask

  task automatic test_random();
    int codes[7] = '{1, 2, 4, 8, 8, 3, 0};
    int r;
    logic [DW-1:0] v;
    do_clr();
    for (int n = 0; n < 80; n++) begin
      if (merr != 0) do_clr();
      r = $urandom_range(0, 9);
      if (r < 5 || (mq.size() < 2 && r < 8)) begin
        v = (r == 0) ? '0 : DW'($urandom);
        if (r == 1) v = DW'($urandom_range(0, 9));
        apply(0, v);
      end else begin
        apply(1, DW'(codes[$urandom_range(0, 6)]));
      end
      @(negedge clk);
      checks++;
      if (obs_vec() !== exp_vec())
        $display("FAIL random[%0d]: got %h want %h",
                 n, obs_vec(), exp_vec());
      else passed++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_add();
    test_sub_mul();
    test_div0();
    test_overflow();
    test_underflow_badop();
    test_rst_exec();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/rpn_sequencer.md
# rpn_sequencer

Reverse-Polish sequencer for the calculator's combinational ALU. Accepts a stream of operand and operator tokens through a valid/ready handshake and keeps operands on an internal register stack. For each operator it pops the top two entries, drives the external ALU, and pushes the result. Sits between the token front end (keypad/queue) and the ALU, which is instantiated beside it at the top level.

## Interface
- DATA_W, 32, operand/result width
- DEPTH, 8, stack entries (≥2)
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- clr  in  1  synchronous clear: empties stack, clears error, returns to IDLE
- in_valid  in  1  token present
- in_ready  out  1  token accepted when in_valid && in_ready
- in_is_op  in  1  1 = operator token, 0 = operand token
- in_data  in  DATA_W  operand value; for operators, bits [3:0] carry the op code
- alu_a  out  DATA_W  ALU operand A (second-from-top)
- alu_b  out  DATA_W  ALU operand B (top)
- alu_op  out  4  one-hot op: 0001 add, 0010 sub, 0100 mul, 1000 div
- alu_y  in  DATA_W  ALU result, combinational from alu_a/alu_b/alu_op
- top  out  DATA_W  current top-of-stack value (0 when empty)
- count  out  $clog2(DEPTH+1)  entries on stack
- busy  out  1  high in EXEC
- err  out  1  sticky error flag
- err_code  out  3  0 none, 1 overflow, 2 underflow, 3 bad op, 4 divide-by-zero

## Operation
- States: IDLE, EXEC, ERR.
- Reset/clr: state IDLE, count 0, top 0, alu_a/alu_b 0, alu_op 0000, busy 0, err 0, err_code 0; stack contents don't-care.
- IDLE: in_ready = 1. Operand token: if count < DEPTH, push, count+1; else set err_code 1, go to ERR, stack unchanged.
- IDLE operator token: op not one of the four one-hot codes → err_code 3, ERR. count < 2 → err_code 2, ERR. Otherwise latch A = entry[count-2], B = entry[count-1] and op into alu_a/alu_b/alu_op registers; go to EXEC.
- EXEC: in_ready = 0, busy = 1. At the cycle end, alu_y overwrites entry[count-2] and count decrements; return to IDLE. alu_op returns to 0000 in IDLE.
- ERR: in_ready = 0; stack frozen; only clr or rst exits.
- Arithmetic is entirely the ALU's: results are taken modulo 2^DATA_W; sub is A−B; div is A/B with ALU result 0 for B = 0.
- clr has priority over any token or EXEC completion in the same cycle.
- rst mid-EXEC: operation abandoned, all outputs at reset values.

## Timing
- Operand accepted at edge N: top/count updated after edge N.
- Operator accepted at edge N: alu_* valid after edge N (EXEC), result written at edge N+1; top/count reflect it after N+1; in_ready high again after N+1. One operator costs 2 cycles; back-to-back operands run at 1 per cycle.
- The ALU path is one full cycle (alu_* registered → alu_y → stack register).
- err/err_code are set at the rejecting edge and hold until clr/rst.

## Configuration
- RPN_DIV0_TRAP_EN defined: a div operator with B = 0 is rejected in IDLE with err_code 4 → ERR; the stack is unchanged and EXEC is not entered.
- Undefined: div by 0 executes normally and pushes the ALU's 0; err_code 4 never occurs.

## Structure
- Package rpn_pkg: OP_ADD/OP_SUB/OP_MUL/OP_DIV one-hot constants, err_code constants, state enum type.
- Sub-module rpn_stack: DEPTH×DATA_W register array with push, replace-second-and-pop, clear, exposing count, top, and second. The sequencer FSM wraps it.

## Test plan
- Push 5, push 3, op 0001 → after the operator edge+1: count 1, top 8; in_ready low exactly one cycle.
- Push 0, push 0x0000FFFF, op 0010 → top 0xFFFF0001; push 0xFFFF, 0xFFFF, op 0100 → top 0xFFFE0001.
- Push 7, push 0, op 1000 → macro undefined: top 0, count 1; macro defined: err 1, err_code 4, count 2, top 0.
- Push DEPTH+1 operands → err_code 1, count DEPTH, in_ready 0; clr → count 0, err 0, in_ready 1.
- Single operand then op 0001 → err_code 2; op 0011 with 2 entries → err_code 3; stack unchanged in both.
- Assert rst during EXEC → all outputs at reset values immediately; next push 9 gives count 1, top 9.
